wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 and the register index width at 5.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  reset, synchronous, active-low.
REQ-004 alu_req  in  1  ALU writeback request valid.
REQ-005 alu_dest  in  5  ALU destination register index.
REQ-006 alu_data  in  32  ALU result.
REQ-007 alu_ready  out  1  ALU request accepted this cycle.
REQ-008 mem_req  in  1  load writeback request valid.
REQ-009 mem_dest  in  5  load destination register index.
REQ-010 mem_data  in  32  load data.
REQ-011 mem_ready  out  1  load request accepted this cycle.
REQ-012 rsv_valid  in  1  issue stage reserves a destination for an outstanding load.
REQ-013 rsv_dest  in  5  reserved register index.
REQ-014 chk_src1  in  5  first source index of the instruction in decode.
REQ-015 chk_src2  in  5  second source index of the instruction in decode.
REQ-016 stall  out  1  decode must hold: a source is reserved.
REQ-017 rf_write_enable  out  1  register-file write strobe.
REQ-018 rf_dest  out  5  register-file write index.
REQ-019 rf_data  out  32  register-file write data.
REQ-020 rf_dest_sel  out  1  constant 1; selects the explicit destination field.

Function
REQ-021 A transfer SHALL occur at a posedge where req and ready are both high; requesters SHALL hold req/dest/data stable until accepted, and req SHALL NOT depend on ready.
REQ-022 Grant SHALL be combinational: a single requester is granted; if both request, the requester not granted last is granted (round-robin); at most one ready is high per cycle.
REQ-023 A 1-bit last_grant register SHALL update only on a transfer (0=ALU, 1=MEM).
REQ-024 rf_write_enable/rf_dest/rf_data SHALL be registered: a transfer at posedge N drives them throughout cycle N+1, so the register file captures at the negedge inside cycle N+1.
REQ-025 With no transfer at a posedge, rf_write_enable SHALL be 0 in the following cycle; rf_dest/rf_data SHALL hold their previous values.
REQ-026 A transfer with dest 0 SHALL be accepted but SHALL drive rf_write_enable 0.
REQ-027 A 32-bit busy scoreboard SHALL set bit rsv_dest on rsv_valid (except index 0) and clear bit dest on any MEM transfer.
REQ-028 If a reserve and a MEM clear target the same index in the same cycle, the reserve SHALL win (bit stays 1).
REQ-029 A reserve of an already-busy index SHALL leave it busy; no counting.
REQ-030 ALU transfers SHALL NOT modify the scoreboard.
REQ-031 stall SHALL be combinational: (busy[chk_src1] and chk_src1!=0) or (busy[chk_src2] and chk_src2!=0).
REQ-032 stall SHALL deassert in the cycle after the clearing MEM transfer; no bypass of rf_data is provided.

Reset
REQ-033 While reset is 0 at a posedge: rf_write_enable=0, rf_dest=0, rf_data=0, last_grant=1 (ALU wins the first contention), and busy=0.
REQ-034 alu_ready and mem_ready SHALL be 0 while reset is low; stall SHALL be 0 after the reset edge.
REQ-035 A request pending across reset SHALL be lost; the requester re-presents it after reset.

Structure
REQ-036 The data width (32), the index width (5) and the grant encodings SHALL be defined as constants in the shared CPU package.
REQ-037 The busy scoreboard SHALL be a sub-module, wb_scoreboard (set/clear/two lookup ports).

Verification
REQ-038 Verify: alu_req with dest 5, data 0x1234 -> alu_ready=1 immediately; next cycle rf_write_enable=1, rf_dest=5, rf_data=0x1234.
REQ-039 Verify: both requesters held high for 4 cycles after reset -> grants alternate ALU, MEM, ALU, MEM.
REQ-040 Verify: rsv_valid on dest 8, then chk_src1=8 -> stall=1; MEM transfer to 8 -> stall=0 the next cycle and rf_dest=8.
REQ-041 Verify: same-cycle reserve of 9 and MEM clear of 9 -> busy[9] stays 1 and chk_src2=9 keeps stall=1.
REQ-042 Verify: ALU transfer to dest 0 -> alu_ready=1 and rf_write_enable stays 0; rsv_valid on 0 -> stall never asserts.
REQ-043 Verify: reset asserted with busy bits set and a request pending -> all outputs 0 and busy clear after the edge; the first contention after reset grants ALU.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared CPU constants for the writeback path.
// Defines the data and register-index widths, the register count, and the
// encoding of the round-robin grant state. Every writeback module imports it.
package wb_arbiter_pkg;

  localparam int DATA_W   = 32;
  localparam int IDX_W    = 5;
  localparam int NUM_REGS = 1 << IDX_W;

  // last_grant encoding: which requester won the most recent transfer.
  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for registers that have an outstanding load.
// One bit per architectural register. A reserve sets a bit and a load
// writeback clears it. Two combinational lookup ports serve decode.
// Ports:
//   clk, reset             clock, synchronous active-low reset (clears all bits)
//   set_valid, set_idx     reserve request (index 0 is never marked busy)
//   clr_valid, clr_idx     clear request from a load writeback
//   lk1_idx/lk1_busy       lookup port 1
//   lk2_idx/lk2_busy       lookup port 2
module wb_scoreboard
  import wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             set_valid,
  input  logic [IDX_W-1:0] set_idx,
  input  logic             clr_valid,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] lk1_idx,
  output logic             lk1_busy,
  input  logic [IDX_W-1:0] lk2_idx,
  output logic             lk2_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  // The set is applied after the clear. When a reserve and a clear hit the
  // same index in one cycle, the reserve therefore wins: a new load has
  // claimed the register while the old one retires.
  always_comb begin
    // NOTE: default every combinational output first so no path leaves it unassigned (no latch).
    busy_next = busy;
    if (clr_valid) busy_next[clr_idx] = 1'b0;
    if (set_valid && (set_idx != '0)) busy_next[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: this bit array is live pipeline state, not a data store, so it must be reset.
    if (!reset) begin
      busy <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      busy <= busy_next;
    end
  end

  assign lk1_busy = busy[lk1_idx];
  assign lk2_busy = busy[lk2_idx];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter with a load-use scoreboard.
// Two requesters, the ALU and the load unit, compete for the single
// register-file write port. Grants are combinational round-robin. The
// write strobe, index and data are registered. A busy scoreboard tracks
// destinations of outstanding loads and stalls decode when a source is busy.
// Ports:
//   clk, reset                        clock, synchronous active-low reset
//   alu_req/alu_dest/alu_data         ALU writeback request
//   alu_ready                         ALU accepted this cycle
//   mem_req/mem_dest/mem_data         load writeback request
//   mem_ready                         load accepted this cycle
//   rsv_valid/rsv_dest                reserve a destination for a pending load
//   chk_src1/chk_src2                 decode source indices
//   stall                             decode must hold
//   rf_write_enable/rf_dest/rf_data   register-file write port
//   rf_dest_sel                       always 1, selects the explicit dest field
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_req,
  input  logic [IDX_W-1:0]  alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_req,
  input  logic [IDX_W-1:0]  mem_dest,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              rsv_valid,
  input  logic [IDX_W-1:0]  rsv_dest,
  input  logic [IDX_W-1:0]  chk_src1,
  input  logic [IDX_W-1:0]  chk_src2,
  output logic              stall,
  output logic              rf_write_enable,
  output logic [IDX_W-1:0]  rf_dest,
  output logic [DATA_W-1:0] rf_data,
  output logic              rf_dest_sel
);

  grant_e last_grant;
  logic   alu_fire;
  logic   mem_fire;
  logic   src1_busy;
  logic   src2_busy;

  // A lone requester always wins. Under contention the requester that did
  // not win last time wins. Nothing is granted during reset, so a request
  // held across reset is dropped.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (reset) begin
      alu_ready = alu_req && (!mem_req || (last_grant == GRANT_MEM));
      mem_ready = mem_req && (!alu_req || (last_grant == GRANT_ALU));
    end
  end

  assign alu_fire = alu_req && alu_ready;
  assign mem_fire = mem_req && mem_ready;

  // last_grant resets to MEM so the ALU wins the first contention.
  // A dest-0 transfer is still consumed but never strobes the register file.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant      <= GRANT_MEM;
      rf_write_enable <= 1'b0;
      rf_dest         <= '0;
      rf_data         <= '0;
    end else if (alu_fire) begin
      last_grant      <= GRANT_ALU;
      rf_write_enable <= (alu_dest != '0);
      rf_dest         <= alu_dest;
      rf_data         <= alu_data;
    end else if (mem_fire) begin
      last_grant      <= GRANT_MEM;
      rf_write_enable <= (mem_dest != '0);
      rf_dest         <= mem_dest;
      rf_data         <= mem_data;
    end else begin
      rf_write_enable <= 1'b0;
    end
  end

  // Only load writebacks retire a reservation. ALU results never touch the
  // scoreboard.
  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_valid (rsv_valid),
    .set_idx   (rsv_dest),
    .clr_valid (mem_fire),
    .clr_idx   (mem_dest),
    .lk1_idx   (chk_src1),
    .lk1_busy  (src1_busy),
    .lk2_idx   (chk_src2),
    .lk2_busy  (src2_busy)
  );

  // No bypass: decode waits until the load's write has landed, which is the
  // cycle after the clearing transfer.
  assign stall = (src1_busy && (chk_src1 != '0)) ||
                 (src2_busy && (chk_src2 != '0));

  assign rf_dest_sel = 1'b1;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        alu_req;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_req;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        rsv_valid;
  logic [4:0]  rsv_dest;
  logic [4:0]  chk_src1;
  logic [4:0]  chk_src2;
  logic        stall;
  logic        rf_write_enable;
  logic [4:0]  rf_dest;
  logic [31:0] rf_data;
  logic        rf_dest_sel;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_busy [32];
  bit          m_last_mem;    // 1 when the load unit won the last transfer
  bit          m_we;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  bit          m_dest_known;  // 0 after a dest-0 transfer: dest/data are not compared

  wb_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .alu_req         (alu_req),
    .alu_dest        (alu_dest),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_req         (mem_req),
    .mem_dest        (mem_dest),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .rsv_valid       (rsv_valid),
    .rsv_dest        (rsv_dest),
    .chk_src1        (chk_src1),
    .chk_src2        (chk_src2),
    .stall           (stall),
    .rf_write_enable (rf_write_enable),
    .rf_dest         (rf_dest),
    .rf_data         (rf_data),
    .rf_dest_sel     (rf_dest_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    return (chk_src1 != 0 && m_busy[chk_src1]) || (chk_src2 != 0 && m_busy[chk_src2]);
  endfunction

  // One clock cycle. Inputs are already driven (at a negedge). Combinational
  // outputs are checked just before the posedge, registered outputs #1 after
  // it, and the task returns at the next negedge. ga/gm: model grants.
  // oa/om: sampled DUT readies.
  task automatic cycle(output bit ga, output bit gm, output bit oa, output bit om);
    #2;
    ga = reset && alu_req && (!mem_req || m_last_mem);
    gm = reset && mem_req && (!alu_req || !m_last_mem);
    oa = alu_ready;
    om = mem_ready;
    check("alu_ready", {31'b0, alu_ready}, {31'b0, ga});
    check("mem_ready", {31'b0, mem_ready}, {31'b0, gm});
    check("stall", {31'b0, stall}, {31'b0, model_stall()});
    @(posedge clk);
    if (!reset) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last_mem   = 1'b1;
      m_we         = 1'b0;
      m_dest       = '0;
      m_data       = '0;
      m_dest_known = 1'b1;
    end else begin
      if (ga) begin
        m_we = (alu_dest != 0); m_dest = alu_dest; m_data = alu_data;
        m_dest_known = (alu_dest != 0); m_last_mem = 1'b0;
      end else if (gm) begin
        m_we = (mem_dest != 0); m_dest = mem_dest; m_data = mem_data;
        m_dest_known = (mem_dest != 0); m_last_mem = 1'b1;
        m_busy[mem_dest] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (rsv_valid && rsv_dest != 0) m_busy[rsv_dest] = 1'b1;
    end
    #1;
    check("rf_we", {31'b0, rf_write_enable}, {31'b0, m_we});
    check("rf_dest_sel", {31'b0, rf_dest_sel}, 32'd1);
    if (m_dest_known) begin
      check("rf_dest", {27'b0, rf_dest}, {27'b0, m_dest});
      check("rf_data", rf_data, m_data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alu_req = 0; alu_dest = 0; alu_data = 0;
    mem_req = 0; mem_dest = 0; mem_data = 0;
    rsv_valid = 0; rsv_dest = 0;
    chk_src1 = 0; chk_src2 = 0;
  endtask

  initial begin
    bit ga, gm, oa, om;
    bit a_pend, m_pend;
    bit [1:0] seq_alu, seq_mem;

    // Model starts unknown; the reset cycles below define it.
    m_last_mem = 1'b1; m_we = 0; m_dest = 0; m_data = 0; m_dest_known = 0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    cycle(ga, gm, oa, om);
    cycle(ga, gm, oa, om);
    reset = 1'b1;
    check("reset_we", {31'b0, rf_write_enable}, 32'd0);
    check("reset_dest", {27'b0, rf_dest}, 32'd0);
    check("reset_data", rf_data, 32'd0);

    // Single ALU write of 0x1234 to r5
    alu_req = 1; alu_dest = 5; alu_data = 32'h1234;
    cycle(ga, gm, oa, om);
    check("alu_imm_ready", {31'b0, oa}, 32'd1);
    check("alu_wr_we", {31'b0, rf_write_enable}, 32'd1);
    check("alu_wr_dest", {27'b0, rf_dest}, 32'd5);
    check("alu_wr_data", rf_data, 32'h1234);
    alu_req = 0;
    cycle(ga, gm, oa, om);

    // Contention right after reset: ALU, MEM, ALU, MEM
    reset = 0; cycle(ga, gm, oa, om); reset = 1;
    alu_req = 1; alu_dest = 1; alu_data = 32'hA;
    mem_req = 1; mem_dest = 2; mem_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      cycle(ga, gm, oa, om);
      seq_alu[i % 2] = oa;
      seq_mem[i % 2] = om;
      check($sformatf("rr_alu_%0d", i), {31'b0, oa}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_mem_%0d", i), {31'b0, om}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end
    idle_inputs();

    // Reserve r8, stall on it, then clear it with a load
    rsv_valid = 1; rsv_dest = 8;
    cycle(ga, gm, oa, om);
    rsv_valid = 0; chk_src1 = 8;
    #1 check("rsv8_stall", {31'b0, stall}, 32'd1);
    mem_req = 1; mem_dest = 8; mem_data = 32'hCAFE;
    cycle(ga, gm, oa, om);
    mem_req = 0;
    #1 check("clr8_stall", {31'b0, stall}, 32'd0);
    check("clr8_dest", {27'b0, rf_dest}, 32'd8);
    cycle(ga, gm, oa, om);

    // Reserve and clear of r9 in the same cycle: reserve wins
    chk_src1 = 0; chk_src2 = 9;
    rsv_valid = 1; rsv_dest = 9;
    cycle(ga, gm, oa, om);
    mem_req = 1; mem_dest = 9; mem_data = 32'h99;
    cycle(ga, gm, oa, om);
    rsv_valid = 0; mem_req = 0;
    #1 check("rsv9_wins_stall", {31'b0, stall}, 32'd1);
    cycle(ga, gm, oa, om);

    // Dest-0 ALU transfer and reserve of r0
    idle_inputs();
    alu_req = 1; alu_dest = 0; alu_data = 32'hDEAD;
    cycle(ga, gm, oa, om);
    check("dest0_ready", {31'b0, oa}, 32'd1);
    check("dest0_we", {31'b0, rf_write_enable}, 32'd0);
    alu_req = 0; rsv_valid = 1; rsv_dest = 0;
    cycle(ga, gm, oa, om);
    rsv_valid = 0;
    #1 check("rsv0_stall", {31'b0, stall}, 32'd0);
    cycle(ga, gm, oa, om);

    // Reset with busy bits set and a request pending
    rsv_valid = 1; rsv_dest = 3; cycle(ga, gm, oa, om);
    rsv_dest = 4; cycle(ga, gm, oa, om);
    rsv_valid = 0; chk_src1 = 3; chk_src2 = 4;
    alu_req = 1; alu_dest = 6; alu_data = 32'h66;
    cycle(ga, gm, oa, om);  // ALU wins, last grant = ALU
    mem_req = 1; mem_dest = 7; mem_data = 32'h77;
    reset = 0;
    cycle(ga, gm, oa, om);
    check("rst_alu_ready", {31'b0, oa}, 32'd0);
    check("rst_mem_ready", {31'b0, om}, 32'd0);
    reset = 1;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_we", {31'b0, rf_write_enable}, 32'd0);
    check("rst_dest", {27'b0, rf_dest}, 32'd0);
    check("rst_data", rf_data, 32'd0);
    cycle(ga, gm, oa, om);
    check("post_rst_alu_first", {31'b0, oa}, 32'd1);
    idle_inputs();
    cycle(ga, gm, oa, om);

    // Randomized traffic; requesters hold their request until accepted
    a_pend = 0; m_pend = 0;
    for (int n = 0; n < 400; n++) begin
      if (!a_pend && ($urandom_range(0, 1) == 1)) begin
        a_pend = 1; alu_dest = 5'($urandom_range(0, 7)); alu_data = $urandom;
      end
      if (!m_pend && ($urandom_range(0, 1) == 1)) begin
        m_pend = 1; mem_dest = 5'($urandom_range(0, 7)); mem_data = $urandom;
      end
      alu_req = a_pend;
      mem_req = m_pend;
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_dest = 5'($urandom_range(0, 7));
      chk_src1 = 5'($urandom_range(0, 7));
      chk_src2 = 5'($urandom_range(0, 7));
      reset = ($urandom_range(0, 63) != 0);
      cycle(ga, gm, oa, om);
      if (!reset) begin
        a_pend = 0; m_pend = 0;
        reset = 1;
      end
      if (ga) a_pend = 0;
      if (gm) m_pend = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
